// File: rtl/puf_pkg.sv
// Shared definitions for the arbiter-PUF challenge sequencer: FSM states,
// challenge width and the challenge LFSR polynomial.
package puf_pkg;

    localparam int CHAL_W = 64;

    // Fibonacci taps 64,63,61,60 expressed as bit positions 63,62,60,59
    localparam logic [CHAL_W-1:0] LFSR_TAPS    = 64'hD800_0000_0000_0000;
    localparam logic [CHAL_W-1:0] LFSR_DEFAULT = 64'h1;

    typedef enum logic [2:0] {
        IDLE,
        APPLY,
        LAUNCH,
        SAMPLE,
        RELAX,
        DONE
    } puf_state_t;

    // One left shift of the challenge LFSR, feedback parity entering bit 0
    function automatic logic [CHAL_W-1:0] lfsr_next(input logic [CHAL_W-1:0] cur);
        return {cur[CHAL_W-2:0], ^(cur & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/puf_sync2.sv
// Two-flop synchronizer bringing the asynchronous arbiter latch output
// into the clk domain.
module puf_sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    // Double-register the asynchronous input; both flops clear on reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/puf_challenge_sequencer.sv
// Arbiter-PUF challenge sequencer: steps an LFSR challenge onto the delay
// chain, fires a launch edge per evaluation, samples the synchronized
// arbiter decision and assembles OUT_WIDTH bits into a response word.
module puf_challenge_sequencer
    import puf_pkg::*;
#(
    parameter int SETTLE_CYCLES = 8,
    parameter int OUT_WIDTH     = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 seed_load,
    input  logic [CHAL_W-1:0]    seed,
    output logic [CHAL_W-1:0]    challenge,
    output logic                 launch,
    input  logic                 arb_resp,
    output logic [OUT_WIDTH-1:0] rnd_data,
    output logic                 rnd_valid,
    input  logic                 rnd_ready,
    output logic                 busy
);

    localparam int         CNT_W       = $clog2(OUT_WIDTH + 1);
    localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);

    puf_state_t          state;
    logic [CHAL_W-1:0]   lfsr;
    logic [7:0]          settle_cnt;
    logic [CNT_W-1:0]    bit_cnt;
    logic                arb_sync;

    // The LFSR register drives the mux selects directly, so the challenge
    // only moves when the LFSR does (RELAX entry or a seed load in IDLE)
    assign challenge = lfsr;

    puf_sync2 u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (arb_resp),
        .q     (arb_sync)
    );

    // Sequencer FSM with registered launch/valid/busy, LFSR and response shifter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            lfsr       <= LFSR_DEFAULT;
            settle_cnt <= '0;
            bit_cnt    <= '0;
            rnd_data   <= '0;
            launch     <= 1'b0;
            rnd_valid  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (seed_load) begin
                        lfsr <= (seed == '0) ? LFSR_DEFAULT : seed;
                    end
                    if (start) begin
                        state    <= APPLY;
                        busy     <= 1'b1;
                        bit_cnt  <= '0;
                        rnd_data <= '0;
                    end
                end
                APPLY: begin
                    state      <= LAUNCH;
                    launch     <= 1'b1;
                    settle_cnt <= SETTLE_LOAD;
                end
                LAUNCH: begin
                    if (settle_cnt == 8'd0) begin
                        state <= SAMPLE;
                    end else begin
                        settle_cnt <= settle_cnt - 8'd1;
                    end
                end
                SAMPLE: begin
                    rnd_data   <= (rnd_data << 1) | OUT_WIDTH'(arb_sync);
                    bit_cnt    <= bit_cnt + CNT_W'(1);
                    launch     <= 1'b0;
                    lfsr       <= lfsr_next(lfsr);
                    settle_cnt <= SETTLE_LOAD;
                    state      <= RELAX;
                end
                RELAX: begin
                    if (settle_cnt == 8'd0) begin
                        state <= (bit_cnt == CNT_W'(OUT_WIDTH)) ? DONE : APPLY;
                    end else begin
                        settle_cnt <= settle_cnt - 8'd1;
                    end
                end
                DONE: begin
                    if (rnd_valid && rnd_ready) begin
                        state     <= IDLE;
                        rnd_valid <= 1'b0;
                        busy      <= 1'b0;
                    end else begin
                        rnd_valid <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_puf_challenge_sequencer.sv
// Self-checking bench for puf_challenge_sequencer: a behavioural delay-chain
// response model feeds arb_resp, expected words go into a scoreboard queue
// when start is driven and are popped when rnd_valid appears.
module tb_puf_challenge_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        start, seed_load, rnd_ready, launch, arb_resp, rnd_valid, busy;
    logic [63:0] seed, challenge;
    logic [31:0] rnd_data;

    logic        start4, seed_load4, rnd_ready4, launch4, arb_resp4, rnd_valid4, busy4;
    logic [63:0] seed4, challenge4;
    logic [3:0]  rnd_data4;

    int          checks = 0;
    int          errors = 0;
    int          arb_mode = 0;
    logic [63:0] sb[$];
    logic [63:0] sb4[$];
    logic [63:0] model_lfsr  = 64'h1;
    logic [63:0] model_lfsr4 = 64'h1;
    logic [63:0] last_exp;

    always #5 clk = ~clk;

    puf_challenge_sequencer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .seed_load (seed_load),
        .seed      (seed),
        .challenge (challenge),
        .launch    (launch),
        .arb_resp  (arb_resp),
        .rnd_data  (rnd_data),
        .rnd_valid (rnd_valid),
        .rnd_ready (rnd_ready),
        .busy      (busy)
    );

    puf_challenge_sequencer #(.SETTLE_CYCLES(8), .OUT_WIDTH(4)) dut4 (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start4),
        .seed_load (seed_load4),
        .seed      (seed4),
        .challenge (challenge4),
        .launch    (launch4),
        .arb_resp  (arb_resp4),
        .rnd_data  (rnd_data4),
        .rnd_valid (rnd_valid4),
        .rnd_ready (rnd_ready4),
        .busy      (busy4)
    );

    // Reference LFSR step written straight from the tap list 64,63,61,60
    function automatic logic [63:0] lfsrStep(input logic [63:0] l);
        return {l[62:0], l[63] ^ l[62] ^ l[60] ^ l[59]};
    endfunction

    // Behavioural chain+arbiter: constant 1, challenge[0], or a parity of selects
    function automatic logic respModel(input logic [63:0] c, input int mode);
        case (mode)
            0:       return 1'b1;
            1:       return c[0];
            default: return ^(c & 64'h9E37_79B9_7F4A_7C15);
        endcase
    endfunction

    assign arb_resp  = respModel(challenge, arb_mode);
    assign arb_resp4 = respModel(challenge4, 1);

    // Single comparison point: counts every check and reports mismatches
    task automatic checkOutput(input string tag, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
        end
    endtask

    // Advance one cycle and settle just after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse start (optionally with seed_load) and push the predicted word
    task automatic applyStimulus(input bit w4, input logic [63:0] seed_val, input bit do_seed);
        logic [63:0] l;
        logic [63:0] word;
        int width;
        width = w4 ? 4 : 32;
        l = w4 ? model_lfsr4 : model_lfsr;
        if (do_seed) l = (seed_val == 64'h0) ? 64'h1 : seed_val;
        word = '0;
        for (int i = 0; i < width; i++) begin
            word = {word[62:0], respModel(l, w4 ? 1 : arb_mode)};
            l = lfsrStep(l);
        end
        if (w4) begin
            model_lfsr4 = l;
            sb4.push_back(word);
            seed4 = seed_val; seed_load4 = do_seed; start4 = 1'b1;
        end else begin
            model_lfsr = l;
            sb.push_back(word);
            seed = seed_val; seed_load = do_seed; start = 1'b1;
        end
        tick();
        start = 1'b0; seed_load = 1'b0; start4 = 1'b0; seed_load4 = 1'b0;
    endtask

    // Wait (bounded) for rnd_valid, checking latency, launch width and word
    task automatic waitWord(input bit w4, input int exp_lat, input bit disturb);
        int n, run, viol;
        bit got;
        logic v, lch, prev_lch;
        logic [63:0] chal, prev_chal, data, exp_word;
        n = 0; run = 0; viol = 0; got = 1'b0;
        prev_lch = w4 ? launch4 : launch;
        prev_chal = w4 ? challenge4 : challenge;
        while (n < 2000 && !got) begin
            tick();
            n++;
            v    = w4 ? rnd_valid4 : rnd_valid;
            lch  = w4 ? launch4 : launch;
            chal = w4 ? challenge4 : challenge;
            if (prev_lch && lch && chal !== prev_chal) viol++;
            prev_lch = lch; prev_chal = chal;
            if (w4) begin
                if (lch) run++;
                else if (run > 0) begin
                    checkOutput("launch_len", 64'(run), 64'd9);
                    run = 0;
                end
            end
            if (v) got = 1'b1;
            else if (disturb && (n == 100 || n == 301 || n == 450)) begin
                start = 1'b1; seed_load = 1'b1;
                seed = {$urandom(), $urandom()};
            end else begin
                start = 1'b0; seed_load = 1'b0;
            end
        end
        start = 1'b0; seed_load = 1'b0;
        checkOutput("valid_seen", 64'(got), 64'd1);
        checkOutput("chal_stable_in_launch", 64'(viol), 64'd0);
        if (got) begin
            checkOutput("latency", 64'(n), 64'(exp_lat));
            checkOutput("busy_done", 64'(w4 ? busy4 : busy), 64'd1);
            checkOutput("sb_nonempty", 64'(w4 ? sb4.size() : sb.size()), 64'd1);
            if (w4 ? sb4.size() > 0 : sb.size() > 0) begin
                exp_word = w4 ? sb4.pop_front() : sb.pop_front();
                data = w4 ? 64'(rnd_data4) : 64'(rnd_data);
                checkOutput("rnd_data", data, exp_word);
                last_exp = exp_word;
            end
        end
    endtask

    // Accept the word and confirm return to IDLE on that edge
    task automatic handshake(input bit w4);
        if (w4) rnd_ready4 = 1'b1; else rnd_ready = 1'b1;
        tick();
        rnd_ready = 1'b0; rnd_ready4 = 1'b0;
        checkOutput("valid_after_ready", 64'(w4 ? rnd_valid4 : rnd_valid), 64'd0);
        checkOutput("busy_after_ready", 64'(w4 ? busy4 : busy), 64'd0);
    endtask

    // Main test sequence
    initial begin
        int rises;
        int k;
        start = 0; seed_load = 0; rnd_ready = 0; seed = '0;
        start4 = 0; seed_load4 = 0; rnd_ready4 = 0; seed4 = '0;

        #12;
        checkOutput("rst_challenge", challenge, 64'h1);
        checkOutput("rst_launch", 64'(launch), 64'd0);
        checkOutput("rst_valid", 64'(rnd_valid), 64'd0);
        checkOutput("rst_busy", 64'(busy), 64'd0);
        checkOutput("rst_data", 64'(rnd_data), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        seed = 64'hDEAD_BEEF_0123_4567; seed_load = 1'b1;
        tick();
        seed_load = 1'b0;
        checkOutput("seed_load", challenge, 64'hDEAD_BEEF_0123_4567);
        seed = 64'h0; seed_load = 1'b1;
        tick();
        seed_load = 1'b0;
        checkOutput("seed_zero", challenge, 64'h1);
        model_lfsr = 64'h1;

        $display("[TB] all-ones response, default parameters");
        arb_mode = 0;
        applyStimulus(0, 64'h0, 0);
        waitWord(0, 577, 0);
        checkOutput("ones_const", 64'(rnd_data), 64'hFFFF_FFFF);
        for (int i = 0; i < 50; i++) begin
            tick();
            checkOutput("hold_valid", 64'(rnd_valid), 64'd1);
            checkOutput("hold_data", 64'(rnd_data), last_exp);
        end
        handshake(0);

        $display("[TB] parity response, seed with start, mid-word disturbance");
        arb_mode = 2;
        applyStimulus(0, 64'h0F1E_2D3C_4B5A_6978, 1);
        waitWord(0, 577, 1);
        checkOutput("lfsr_after_word", challenge, model_lfsr);
        handshake(0);

        $display("[TB] reset during LAUNCH");
        arb_mode = 1;
        start = 1'b1;
        tick();
        start = 1'b0;
        k = 0;
        while (!launch && k < 20) begin
            tick();
            k++;
        end
        checkOutput("launch_reached", 64'(launch), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("rst_mid_launch", 64'(launch), 64'd0);
        checkOutput("rst_mid_busy", 64'(busy), 64'd0);
        checkOutput("rst_mid_challenge", challenge, 64'h1);
        @(negedge clk);
        rst_n = 1'b1;
        model_lfsr = 64'h1;
        model_lfsr4 = 64'h1;
        rises = 0;
        for (int i = 0; i < 700; i++) begin
            tick();
            if (rnd_valid) rises++;
        end
        checkOutput("no_valid_after_reset", 64'(rises), 64'd0);
        checkOutput("idle_after_reset", 64'(busy), 64'd0);
        applyStimulus(0, 64'h0, 0);
        waitWord(0, 577, 0);
        handshake(0);

        $display("[TB] OUT_WIDTH=4, response = challenge[0]");
        applyStimulus(1, 64'h1, 1);
        waitWord(1, 73, 0);
        checkOutput("w4_const", 64'(rnd_data4), 64'h8);
        handshake(1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/puf_challenge_sequencer.md
PUF_CHALLENGE_SEQUENCER -- requirements
Module: puf_challenge_sequencer

Interface
REQ-001 The block SHALL have parameter SETTLE_CYCLES, default 8: cycles launch is held high, and then held low, per evaluation; legal range 3..255.
REQ-002 The block SHALL have parameter OUT_WIDTH, default 32: response bits per output word; legal range 1..64.
REQ-003 The block SHALL have one clock, clk, and an asynchronous active-low reset, rst_n.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 start  input  1  single-cycle request to generate one word.
REQ-007 seed_load  input  1  loads seed into the challenge LFSR.
REQ-008 seed  input  64  challenge LFSR seed.
REQ-009 challenge  output  64  select lines to the 64 crossed-mux stages of the delay chain.
REQ-010 launch  output  1  rising edge is injected into both chain inputs.
REQ-011 arb_resp  input  1  arbiter latch output; asynchronous to clk.
REQ-012 rnd_data  output  OUT_WIDTH  collected response word.
REQ-013 rnd_valid  output  1  rnd_data is valid.
REQ-014 rnd_ready  input  1  consumer accepts rnd_data.
REQ-015 busy  output  1  high in every state except IDLE.

Function
REQ-016 The FSM SHALL have states IDLE, APPLY, LAUNCH, SAMPLE, RELAX and DONE.
REQ-017 IDLE: start=1 -> APPLY; bit counter cleared; rnd_data shift register cleared.
REQ-018 APPLY lasts 1 cycle; challenge = LFSR; launch=0; next state LAUNCH.
REQ-019 LAUNCH lasts SETTLE_CYCLES cycles with launch=1; next state SAMPLE.
REQ-020 SAMPLE lasts 1 cycle with launch=1: rnd_data <= {rnd_data[OUT_WIDTH-2:0], arb_sync}, so the first bit ends at the MSB; bit counter +1; next state RELAX.
REQ-021 RELAX lasts SETTLE_CYCLES cycles with launch=0; LFSR advances exactly once, on RELAX entry; on exit -> DONE if bit counter == OUT_WIDTH, else APPLY.
REQ-022 DONE: rnd_valid=1 and rnd_data held stable; rnd_valid & rnd_ready -> IDLE on the same edge.
REQ-023 rnd_valid SHALL rise exactly OUT_WIDTH*(2*SETTLE_CYCLES+2)+1 cycles after the edge that samples start (577 at defaults).
REQ-024 challenge SHALL change only on RELAX entry or on seed_load, never while launch=1.
REQ-025 LFSR: 64-bit Fibonacci, taps 64,63,61,60, shifting left, with the feedback bit entering bit 0.
REQ-026 seed_load in IDLE loads seed; seed==0 loads the package constant 64'h1; seed_load is ignored in every state other than IDLE.
REQ-027 start outside IDLE is ignored; start and seed_load together in IDLE: seed loads first, and the first APPLY uses the new seed.
REQ-028 arb_resp SHALL pass through a 2-flop synchronizer to give arb_sync; SAMPLE uses only arb_sync.
REQ-029 rnd_ready while not in DONE has no effect.

Reset
REQ-030 rst_n low SHALL immediately force: state IDLE, launch=0, challenge=64'h1, LFSR=64'h1, rnd_data=0, rnd_valid=0, busy=0, bit counter=0, synchronizer flops=0.
REQ-031 Reset asserted mid-word SHALL discard the partial word; after release, the block waits in IDLE for a new start.

Structure
REQ-032 A shared package puf_pkg SHALL hold the FSM state enum, CHAL_W=64, the LFSR tap constant and LFSR_DEFAULT=64'h1.
REQ-033 The synchronizer SHALL be the sub-module puf_sync2 (two flops, asynchronous active-low reset to 0).
REQ-034 The bench SHALL model the chain and arbiter as a behavioural response function of the challenge.

Verification
REQ-035 Reset, then seed_load seed=64'h0 -> challenge=64'h1.
REQ-036 arb_resp tied 1, start pulse, defaults -> rnd_valid rises 577 cycles later with rnd_data=32'hFFFFFFFF.
REQ-037 arb_resp = challenge[0] from model, OUT_WIDTH=4, seed=64'h1 -> rnd_data matches the first 4 LFSR states; launch is high for 9 cycles per bit.
REQ-038 rnd_ready held 0 for 50 cycles in DONE -> rnd_valid and rnd_data stable; ready=1 -> IDLE next edge, busy=0.
REQ-039 start and seed_load pulsed mid-word -> no effect on the word or the LFSR sequence.
REQ-040 rst_n pulsed low in LAUNCH -> launch=0 immediately; no rnd_valid until a new start.
